// File: rtl/sensor_sweep_sched.sv
// Round-robin IR/battery sweep sequencer owning the shared A2D and IR emitter enables.
// Optional IR_AMBIENT_SUB_EN: per IR slot, convert with emitter off first and subtract ambient.
module sensor_sweep_sched #(
  parameter int unsigned SETTLE_CYC = 512,
  parameter int unsigned PERIOD     = 65536,
  parameter int unsigned CNV_TO     = 4096,
  parameter logic [2:0]  CH_LFT     = 3'd3,
  parameter logic [2:0]  CH_CNTR    = 3'd4,
  parameter logic [2:0]  CH_RGHT    = 3'd0,
  parameter logic [2:0]  CH_BATT    = 3'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        IR_lft_en,
  output logic        IR_cntr_en,
  output logic        IR_rght_en,
  output logic [11:0] lft_IR,
  output logic [11:0] cntr_IR,
  output logic [11:0] rght_IR,
  output logic [11:0] batt,
  output logic        sweep_done,
  output logic        busy,
  output logic        a2d_err
);

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned TW = (CNV_TO > 1) ? $clog2(CNV_TO) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_EMIT, ST_REQ, ST_WAIT, ST_STORE
`ifdef IR_AMBIENT_SUB_EN
    , ST_AMB_REQ, ST_AMB_WAIT
`endif
  } state_t;

  typedef enum logic [1:0] {SL_LFT, SL_CNTR, SL_RGHT, SL_BATT} slot_t;

  state_t        r_state, w_state_nxt;
  slot_t         r_slot, w_slot_nxt;
  logic [PW-1:0] r_per;
  logic          r_pend, w_pend_nxt, w_wrap;
  logic [SW-1:0] r_settle, w_settle_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic          w_tmo_last;
  logic [2:0]    w_chnnl_nxt;
  logic [11:0]   w_lft_nxt, w_cntr_nxt, w_rght_nxt, w_batt_nxt;
  logic [11:0]   w_meas, w_store_val;
  logic          w_store, w_done_nxt, w_err_nxt, w_strt_nxt, w_busy_nxt, w_lit;
  logic          w_lft_en_nxt, w_cntr_en_nxt, w_rght_en_nxt;
`ifdef IR_AMBIENT_SUB_EN
  logic [11:0]   r_amb, w_amb_nxt;
  logic          r_amb_to, w_amb_to_nxt;
`endif

  function automatic state_t slot_entry(input slot_t s);
    state_t st;
`ifdef IR_AMBIENT_SUB_EN
    st = ST_AMB_REQ;
`else
    st = ST_EMIT;
`endif
    if (s == SL_BATT) st = ST_REQ;
    return st;
  endfunction

  function automatic logic [2:0] slot_ch(input slot_t s);
    logic [2:0] ch;
    case (s)
      SL_LFT:  ch = CH_LFT;
      SL_CNTR: ch = CH_CNTR;
      SL_RGHT: ch = CH_RGHT;
      default: ch = CH_BATT;
    endcase
    return ch;
  endfunction

  function automatic slot_t slot_next(input slot_t s);
    slot_t n;
    case (s)
      SL_LFT:  n = SL_CNTR;
      SL_CNTR: n = SL_RGHT;
      SL_RGHT: n = SL_BATT;
      default: n = SL_LFT;
    endcase
    return n;
  endfunction

  assign w_wrap     = (r_per == PW'(PERIOD - 1));
  assign w_tmo_last = (r_tmo == TW'(CNV_TO - 1));

  // Value stored on a good conversion; ambient-corrected for IR slots when enabled
  always_comb begin
`ifdef IR_AMBIENT_SUB_EN
    if (r_slot == SL_BATT)  w_meas = res;
    else if (r_amb_to)      w_meas = 12'hFFF;
    else if (res > r_amb)   w_meas = 12'(res - r_amb);
    else                    w_meas = 12'h000;
`else
    w_meas = res;
`endif
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_slot_nxt   = r_slot;
    w_settle_nxt = '0;
    w_tmo_nxt    = '0;
    w_chnnl_nxt  = chnnl;
    w_lft_nxt    = lft_IR;
    w_cntr_nxt   = cntr_IR;
    w_rght_nxt   = rght_IR;
    w_batt_nxt   = batt;
    w_done_nxt   = 1'b0;
    w_err_nxt    = a2d_err;
    w_store      = 1'b0;
    w_store_val  = 12'h000;
`ifdef IR_AMBIENT_SUB_EN
    w_amb_nxt    = r_amb;
    w_amb_to_nxt = r_amb_to;
`endif

    // A trigger is dropped if one is already pending; disabling cancels it
    if (!en)                              w_pend_nxt = 1'b0;
    else if (r_state == ST_IDLE && r_pend) w_pend_nxt = 1'b0;
    else if (w_wrap)                      w_pend_nxt = 1'b1;
    else                                  w_pend_nxt = r_pend;

    case (r_state)
      ST_IDLE: begin
        if (r_pend) begin
          w_slot_nxt  = SL_LFT;
          w_state_nxt = slot_entry(SL_LFT);
        end
      end
      ST_EMIT: begin
        if (r_settle == SW'(SETTLE_CYC - 1)) w_state_nxt = ST_REQ;
        else                                 w_settle_nxt = SW'(r_settle + 1'b1);
      end
      ST_REQ: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (cnv_cmplt) begin
          w_store     = 1'b1;
          w_store_val = w_meas;
          w_state_nxt = ST_STORE;
        end else if (w_tmo_last) begin
          w_store     = 1'b1;
          w_store_val = 12'hFFF;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_STORE;
        end else begin
          w_tmo_nxt = TW'(r_tmo + 1'b1);
        end
      end
      ST_STORE: begin
        w_slot_nxt  = slot_next(r_slot);
        w_state_nxt = (r_slot == SL_BATT) ? ST_IDLE : slot_entry(slot_next(r_slot));
      end
`ifdef IR_AMBIENT_SUB_EN
      ST_AMB_REQ: w_state_nxt = ST_AMB_WAIT;
      ST_AMB_WAIT: begin
        if (cnv_cmplt) begin
          w_amb_nxt    = res;
          w_amb_to_nxt = 1'b0;
          w_state_nxt  = ST_EMIT;
        end else if (w_tmo_last) begin
          w_amb_to_nxt = 1'b1;
          w_err_nxt    = 1'b1;
          w_state_nxt  = ST_EMIT;
        end else begin
          w_tmo_nxt = TW'(r_tmo + 1'b1);
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_store) begin
      case (r_slot)
        SL_LFT:  w_lft_nxt  = w_store_val;
        SL_CNTR: w_cntr_nxt = w_store_val;
        SL_RGHT: w_rght_nxt = w_store_val;
        default: begin
          w_batt_nxt = w_store_val;
          w_done_nxt = 1'b1;
        end
      endcase
    end

    // Outputs are registered from the next state so they line up with it
    w_lit = (w_state_nxt == ST_EMIT || w_state_nxt == ST_REQ || w_state_nxt == ST_WAIT) &&
            (w_slot_nxt != SL_BATT);
    w_lft_en_nxt  = w_lit && (w_slot_nxt == SL_LFT);
    w_cntr_en_nxt = w_lit && (w_slot_nxt == SL_CNTR);
    w_rght_en_nxt = w_lit && (w_slot_nxt == SL_RGHT);
`ifdef IR_AMBIENT_SUB_EN
    w_strt_nxt = (w_state_nxt == ST_REQ) || (w_state_nxt == ST_AMB_REQ);
`else
    w_strt_nxt = (w_state_nxt == ST_REQ);
`endif
    if (w_strt_nxt) w_chnnl_nxt = slot_ch(w_slot_nxt);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_slot     <= SL_LFT;
      r_per      <= '0;
      r_pend     <= 1'b0;
      r_settle   <= '0;
      r_tmo      <= '0;
      strt_cnv   <= 1'b0;
      chnnl      <= 3'd0;
      IR_lft_en  <= 1'b0;
      IR_cntr_en <= 1'b0;
      IR_rght_en <= 1'b0;
      lft_IR     <= 12'h000;
      cntr_IR    <= 12'h000;
      rght_IR    <= 12'h000;
      batt       <= 12'h000;
      sweep_done <= 1'b0;
      busy       <= 1'b0;
      a2d_err    <= 1'b0;
`ifdef IR_AMBIENT_SUB_EN
      r_amb      <= 12'h000;
      r_amb_to   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_slot     <= w_slot_nxt;
      r_per      <= w_wrap ? '0 : PW'(r_per + 1'b1);
      r_pend     <= w_pend_nxt;
      r_settle   <= w_settle_nxt;
      r_tmo      <= w_tmo_nxt;
      strt_cnv   <= w_strt_nxt;
      chnnl      <= w_chnnl_nxt;
      IR_lft_en  <= w_lft_en_nxt;
      IR_cntr_en <= w_cntr_en_nxt;
      IR_rght_en <= w_rght_en_nxt;
      lft_IR     <= w_lft_nxt;
      cntr_IR    <= w_cntr_nxt;
      rght_IR    <= w_rght_nxt;
      batt       <= w_batt_nxt;
      sweep_done <= w_done_nxt;
      busy       <= w_busy_nxt;
      a2d_err    <= w_err_nxt;
`ifdef IR_AMBIENT_SUB_EN
      r_amb      <= w_amb_nxt;
      r_amb_to   <= w_amb_to_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sensor_sweep_sched.sv
// Directed bench for sensor_sweep_sched with a fixed-latency A2D responder.
module tb_sensor_sweep_sched;
  localparam int unsigned SETTLE = 16;
  localparam int unsigned PER    = 1024;
  localparam int unsigned TO     = 64;
  localparam int          LAT    = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = 12'h000;
  logic        strt_cnv, IR_lft_en, IR_cntr_en, IR_rght_en, sweep_done, busy, a2d_err;
  logic [2:0]  chnnl;
  logic [11:0] lft_IR, cntr_IR, rght_IR, batt;

  int errors = 0;
  int checks = 0;
  int cyc;
  logic drop_cntr = 1'b0;

  sensor_sweep_sched #(.SETTLE_CYC(SETTLE), .PERIOD(PER), .CNV_TO(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .IR_lft_en(IR_lft_en), .IR_cntr_en(IR_cntr_en),
    .IR_rght_en(IR_rght_en), .lft_IR(lft_IR), .cntr_IR(cntr_IR), .rght_IR(rght_IR),
    .batt(batt), .sweep_done(sweep_done), .busy(busy), .a2d_err(a2d_err)
  );

  always #5 clk = ~clk;

  // cyc == n at the negedge following the n-th posedge after reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // A2D responder: cnv_cmplt rises LAT cycles after the strt_cnv cycle; not reset by rst
  int         m_cnt = 0;
  logic [2:0] m_ch  = 3'd0;
`ifdef IR_AMBIENT_SUB_EN
  logic       m_lit = 1'b0;
`endif
  always @(posedge clk) begin
    cnv_cmplt <= 1'b0;
    if (strt_cnv && !(drop_cntr && chnnl == 3'd4)) begin
      m_cnt <= LAT - 1;
      m_ch  <= chnnl;
`ifdef IR_AMBIENT_SUB_EN
      m_lit <= IR_lft_en | IR_cntr_en | IR_rght_en;
`endif
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        cnv_cmplt <= 1'b1;
`ifdef IR_AMBIENT_SUB_EN
        if (!m_lit)             res <= 12'h100;
        else if (m_ch == 3'd3)  res <= 12'h400;
        else if (m_ch == 3'd4)  res <= 12'h080;
        else                    res <= {m_ch, 9'h0A5};
`else
        res <= {m_ch, 9'h0A5};
`endif
      end
    end
  end

  task automatic wait_done(input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sweep_done) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({IR_lft_en, IR_cntr_en, IR_rght_en} !== 3'b000) begin errors++; $display("FAIL reset_en: got %b expected 000", {IR_lft_en, IR_cntr_en, IR_rght_en}); end
    checks++; if (strt_cnv !== 1'b0) begin errors++; $display("FAIL reset_strt: got %b expected 0", strt_cnv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", sweep_done); end
    checks++; if (a2d_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", a2d_err); end
    checks++; if (chnnl !== 3'd0) begin errors++; $display("FAIL reset_chnnl: got %0d expected 0", chnnl); end
    checks++; if ({lft_IR, cntr_IR, rght_IR, batt} !== 48'h0) begin errors++; $display("FAIL reset_readings: got %h expected 0", {lft_IR, cntr_IR, rght_IR, batt}); end
    rst = 1'b0;
  endtask

  task automatic test_first_sweep();
    logic [2:0] exp_ch [4];
    int run_l, run_c, run_r, nstrt, bad_strt, overlap, first_busy, done_at;
    bit ok;
    exp_ch = '{3'd3, 3'd4, 3'd0, 3'd5};
    run_l = 0; run_c = 0; run_r = 0; nstrt = 0; bad_strt = 0; overlap = 0;
    first_busy = -1; ok = 1'b0; done_at = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($countones({IR_lft_en, IR_cntr_en, IR_rght_en}) > 1) overlap++;
      if (busy && first_busy < 0) first_busy = cyc;
      if (strt_cnv) begin
        if (nstrt > 3 || chnnl !== exp_ch[nstrt]) bad_strt++;
        else if (nstrt == 0 && !(IR_lft_en && run_l == int'(SETTLE))) bad_strt++;
        else if (nstrt == 1 && !(IR_cntr_en && run_c == int'(SETTLE))) bad_strt++;
        else if (nstrt == 2 && !(IR_rght_en && run_r == int'(SETTLE))) bad_strt++;
        else if (nstrt == 3 && (IR_lft_en || IR_cntr_en || IR_rght_en)) bad_strt++;
        nstrt++;
      end
      if (cnv_cmplt && (nstrt < 1 || nstrt > 4 || chnnl !== exp_ch[nstrt-1])) bad_strt++;
      run_l = IR_lft_en  ? run_l + 1 : 0;
      run_c = IR_cntr_en ? run_c + 1 : 0;
      run_r = IR_rght_en ? run_r + 1 : 0;
      if (sweep_done) begin ok = 1'b1; done_at = cyc; break; end
    end
    checks++; if (!ok || done_at != int'(PER) + 3*58 + 42) begin errors++; $display("FAIL first_done_time: got %0d expected %0d", done_at, int'(PER) + 3*58 + 42); end
    checks++; if (first_busy != int'(PER) + 1) begin errors++; $display("FAIL first_busy_time: got %0d expected %0d", first_busy, int'(PER) + 1); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL enable_overlap: got %0d expected 0", overlap); end
    checks++; if (nstrt != 4) begin errors++; $display("FAIL strt_count: got %0d expected 4", nstrt); end
    checks++; if (bad_strt != 0) begin errors++; $display("FAIL strt_alignment: got %0d bad expected 0", bad_strt); end
    checks++; if (lft_IR !== 12'h6A5) begin errors++; $display("FAIL lft_IR: got %h expected 6a5", lft_IR); end
    checks++; if (cntr_IR !== 12'h8A5) begin errors++; $display("FAIL cntr_IR: got %h expected 8a5", cntr_IR); end
    checks++; if (rght_IR !== 12'h0A5) begin errors++; $display("FAIL rght_IR: got %h expected 0a5", rght_IR); end
    checks++; if (batt !== 12'hAA5) begin errors++; $display("FAIL batt: got %h expected aa5", batt); end
    checks++; if (a2d_err !== 1'b0) begin errors++; $display("FAIL err_clean: got %b expected 0", a2d_err); end
    @(negedge clk);
    checks++; if ({sweep_done, busy} !== 2'b00) begin errors++; $display("FAIL after_done: got done,busy=%b expected 00", {sweep_done, busy}); end
  endtask

  task automatic test_back_to_back();
    int at; bit ok;
    wait_done(1500, at, ok);
    checks++; if (!ok || at != 2*int'(PER) + 216) begin errors++; $display("FAIL second_done_time: got %0d expected %0d", at, 2*int'(PER) + 216); end
    checks++; if ({lft_IR, cntr_IR, rght_IR, batt} !== 48'h6A5_8A5_0A5_AA5) begin errors++; $display("FAIL second_readings: got %h expected 6a58a50a5aa5", {lft_IR, cntr_IR, rght_IR, batt}); end
  endtask

  task automatic test_timeout();
    int at; bit ok;
    drop_cntr = 1'b1;
    wait_done(1500, at, ok);
    checks++; if (!ok || at != 3*int'(PER) + 58 + (SETTLE + TO + 2) + 58 + 42) begin errors++; $display("FAIL to_done_time: got %0d expected %0d", at, 3*int'(PER) + 58 + int'(SETTLE + TO + 2) + 58 + 42); end
    checks++; if (cntr_IR !== 12'hFFF) begin errors++; $display("FAIL to_cntr: got %h expected fff", cntr_IR); end
    checks++; if (a2d_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", a2d_err); end
    checks++; if ({lft_IR, rght_IR, batt} !== 36'h6A5_0A5_AA5) begin errors++; $display("FAIL to_others: got %h expected 6a50a5aa5", {lft_IR, rght_IR, batt}); end
    drop_cntr = 1'b0;
    wait_done(1500, at, ok);
    checks++; if (!ok || at != 4*int'(PER) + 216) begin errors++; $display("FAIL recover_done_time: got %0d expected %0d", at, 4*int'(PER) + 216); end
    checks++; if (cntr_IR !== 12'h8A5) begin errors++; $display("FAIL recover_cntr: got %h expected 8a5", cntr_IR); end
    checks++; if (a2d_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", a2d_err); end
  endtask

  task automatic test_en_drop();
    bit found; int ndone, busy_after, limit;
    found = 1'b0; ndone = 0; busy_after = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (IR_rght_en) begin found = 1'b1; break; end
    end
    en = 1'b0;
    checks++; if (!found) begin errors++; $display("FAIL en_drop_rght_slot: got no rght enable expected one"); end
    limit = 8*int'(PER) + 8;
    for (int i = 0; i < 5000 && cyc < limit; i++) begin
      @(negedge clk);
      if (ndone > 0 && busy) busy_after++;
      if (sweep_done) ndone++;
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL en_drop_done_count: got %0d expected 1", ndone); end
    checks++; if (busy_after != 0) begin errors++; $display("FAIL en_drop_busy: got %0d busy cycles expected 0", busy_after); end
    checks++; if (a2d_err !== 1'b1) begin errors++; $display("FAIL en_drop_err_sticky: got %b expected 1", a2d_err); end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    bit found; int late, busy_seen;
    found = 1'b0; late = 0; busy_seen = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (strt_cnv) begin found = 1'b1; break; end
    end
    checks++; if (!found || chnnl !== 3'd3) begin errors++; $display("FAIL rst_wait_strt: got found=%b ch=%0d expected 1/3", found, chnnl); end
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if ({IR_lft_en, IR_cntr_en, IR_rght_en, strt_cnv} !== 4'b0000) begin errors++; $display("FAIL rst_async_ctrl: got %b expected 0000", {IR_lft_en, IR_cntr_en, IR_rght_en, strt_cnv}); end
    checks++; if ({lft_IR, cntr_IR, rght_IR, batt} !== 48'h0) begin errors++; $display("FAIL rst_async_readings: got %h expected 0", {lft_IR, cntr_IR, rght_IR, batt}); end
    checks++; if ({busy, a2d_err, sweep_done} !== 3'b000) begin errors++; $display("FAIL rst_async_status: got %b expected 000", {busy, a2d_err, sweep_done}); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (cnv_cmplt) late++;
      if (busy) busy_seen++;
    end
    checks++; if (late != 1) begin errors++; $display("FAIL late_cmplt_seen: got %0d expected 1", late); end
    checks++; if ({lft_IR, cntr_IR, rght_IR, batt} !== 48'h0 || busy_seen != 0) begin errors++; $display("FAIL late_cmplt_ignored: got %h busy=%0d expected 0/0", {lft_IR, cntr_IR, rght_IR, batt}, busy_seen); end
  endtask

`ifdef IR_AMBIENT_SUB_EN
  task automatic test_ambient();
    int at; bit ok;
    wait_done(2500, at, ok);
    checks++; if (!ok) begin errors++; $display("FAIL amb_done: got none expected pulse"); end
    checks++; if (lft_IR !== 12'h300) begin errors++; $display("FAIL amb_lft: got %h expected 300", lft_IR); end
    checks++; if (cntr_IR !== 12'h000) begin errors++; $display("FAIL amb_cntr_sat: got %h expected 000", cntr_IR); end
    checks++; if (batt !== 12'hAA5) begin errors++; $display("FAIL amb_batt: got %h expected aa5", batt); end
    checks++; if (a2d_err !== 1'b0) begin errors++; $display("FAIL amb_err: got %b expected 0", a2d_err); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef IR_AMBIENT_SUB_EN
    test_ambient();
`else
    test_first_sweep();
    test_back_to_back();
    test_timeout();
    test_en_drop();
    test_reset_mid_wait();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
